mem_arbiter: RTL

Arbitrates the single main-memory port between the instruction cache (read-only miss port) and the data cache (read/write port) of the MIPS32 pipeline. Sits between both caches' memory-side ports (`m_a`/`m_strobe`/`m_ready`/`m_dout`) and the memory model or bus. It runs a grant state machine that gives data requests priority, with a bounded-starvation guarantee for instruction fetches. The address and write data are held stable for the whole memory transaction.

---
 rtl/mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between I-cache misses and D-cache accesses; data wins unless the I-side starved.
// Grant 1 cycle after strobe, ready same cycle as m_ready, then one TURN cycle; waits indefinitely on m_ready.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] i_a,
  input  logic        i_strobe,
  output logic [31:0] i_dout,
  output logic        i_ready,
  input  logic [31:0] d_a,
  input  logic [31:0] d_din,
  input  logic        d_rw,
  input  logic        d_strobe,
  output logic [31:0] d_dout,
  output logic        d_ready,
  output logic [31:0] m_a,
  output logic [31:0] m_din,
  output logic        m_rw,
  output logic        m_strobe,
  input  logic [31:0] m_dout,
  input  logic        m_ready,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rw;
  } mreq_t;

  localparam logic [2:0] STREAK_LIM = 3'(MAX_D_STREAK);

  state_t     state, state_nxt;
  mreq_t      req_q;
  logic [2:0] d_streak;
  logic       take_i, take_d;

  always_comb begin
    state_nxt = state;
    take_i    = 1'b0;
    take_d    = 1'b0;
    case (state)
      IDLE: begin
        // Contested arbitration: data wins until it has used up its streak.
        if (i_strobe && d_strobe) begin
          if (d_streak == STREAK_LIM) take_i = 1'b1;
          else                        take_d = 1'b1;
        end else if (i_strobe) begin
          take_i = 1'b1;
        end else if (d_strobe) begin
          take_d = 1'b1;
        end
        if (take_i)      state_nxt = GNT_I;
        else if (take_d) state_nxt = GNT_D;
      end
      GNT_I, GNT_D: begin
        if (m_ready) state_nxt = TURN;
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state    <= IDLE;
      req_q    <= '0;
      d_streak <= 3'd0;
    end else begin
      state <= state_nxt;
      if (take_i) begin
        req_q.addr <= i_a;
        req_q.rw   <= 1'b0;
        d_streak   <= 3'd0;
      end else if (take_d) begin
        req_q.addr  <= d_a;
        req_q.wdata <= d_din;
        req_q.rw    <= d_rw;
        if (i_strobe && d_streak != 3'd7) d_streak <= d_streak + 3'd1;
      end
    end
  end

  assign m_a      = req_q.addr;
  assign m_din    = req_q.wdata;
  assign m_rw     = req_q.rw;
  assign m_strobe = (state == GNT_I) || (state == GNT_D);

  // Ready and read data are combinational so the cache can fill on the completing edge.
  assign i_ready = (state == GNT_I) && m_ready;
  assign d_ready = (state == GNT_D) && m_ready;
  assign i_dout  = (state == GNT_I) ? m_dout : 32'd0;
  assign d_dout  = (state == GNT_D) ? m_dout : 32'd0;

  always_comb begin
    grant = 2'b00;
    if (state == GNT_I)      grant = 2'b01;
    else if (state == GNT_D) grant = 2'b10;
  end

  a_req_stable: assert property (@(posedge clk) disable iff (!clrn)
    (m_strobe && !m_ready) |=> ($stable(m_a) && $stable(m_din) && $stable(m_rw)));

  a_ready_excl: assert property (@(posedge clk) !(i_ready && d_ready));

endmodule
